// File: rtl/lighthouse_report_arbiter.sv
// -----------------------------------------------------------------------------
// lighthouse_report_arbiter
//
// Shares one downstream record sink between NUM lighthouse sensor channels.
// Each channel owns a one-record holding buffer. Buffered records are forwarded
// one at a time, in round-robin order, through a registered valid/ready output
// stage and tagged with the source channel. A record that arrives while its
// channel's buffer is still occupied is dropped. Every drop sets a sticky
// per-channel flag and adds to a saturating counter.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   in_data      NUM packed records; channel k is in_data[k*WIDTH +: WIDTH]
//   in_strobe    one-cycle record-valid pulse for each channel
//   out_data     forwarded record (registered)
//   out_id       source channel of out_data (registered)
//   out_valid    out_data/out_id hold a record (registered)
//   out_ready    sink accepts the presented record this cycle
//   drop_flags   sticky per-channel overrun flags
//   drop_count   saturating total count of dropped records
//   clear_drops  synchronous clear of drop_flags and drop_count
// -----------------------------------------------------------------------------
module lighthouse_report_arbiter #(
    parameter int NUM     = 4,
    parameter int WIDTH   = 72,
    parameter int ID_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM*WIDTH-1:0] in_data,
    input  logic [NUM-1:0]       in_strobe,
    output logic [WIDTH-1:0]     out_data,
    output logic [ID_BITS-1:0]   out_id,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM-1:0]       drop_flags,
    output logic [7:0]           drop_count,
    input  logic                 clear_drops
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_t;

    out_state_t           state_r;
    out_state_t           state_next_s;
    logic [WIDTH-1:0]     hold_r [NUM];
    logic [NUM-1:0]       pending_r;
    logic [ID_BITS-1:0]   rr_ptr_r;

    logic                 load_s;
    logic                 grant_valid_s;
    logic [ID_BITS-1:0]   grant_idx_s;
    logic [ID_BITS-1:0]   cand_s;
    logic [NUM-1:0]       grant_mask_s;
    logic [NUM-1:0]       capture_s;
    logic [NUM-1:0]       drop_s;
    logic [NUM-1:0]       pending_next_s;
    logic [NUM-1:0]       drop_flags_next_s;
    logic [7:0]           count_base_s;
    logic [8:0]           count_sum_s;
    logic [7:0]           drop_count_next_s;

    // Number of set bits in a channel vector, wide enough for any NUM <= 8.
    function automatic logic [7:0] popcount(input logic [NUM-1:0] v);
        logic [7:0] c;
        c = 8'd0;
        for (int i = 0; i < NUM; i++) begin
            c = c + {7'd0, v[i]};
        end
        return c;
    endfunction

    // The output stage can take a new record when empty or when the sink drains it.
    assign load_s    = (state_r == EMPTY) || out_ready;
    assign out_valid = (state_r == FULL);

    // Round-robin search: first pending channel strictly after rr_ptr, wrapping.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        for (int i = 1; i <= NUM; i++) begin
            cand_s = ID_BITS'((int'(rr_ptr_r) + i) % NUM);
            grant_idx_s   = (load_s && !grant_valid_s && pending_r[cand_s]) ? cand_s : grant_idx_s;
            grant_valid_s = grant_valid_s || (load_s && pending_r[cand_s]);
        end
    end

    // Per-channel capture/drop decision. A channel being granted this cycle
    // frees its buffer, so a same-cycle strobe refills it instead of dropping.
    always_comb begin
        grant_mask_s = '0;
        capture_s    = '0;
        drop_s       = '0;
        for (int k = 0; k < NUM; k++) begin
            grant_mask_s[k] = grant_valid_s && (grant_idx_s == ID_BITS'(k));
            capture_s[k]    = in_strobe[k] && (!pending_r[k] || grant_mask_s[k]);
            drop_s[k]       = in_strobe[k] && !capture_s[k];
        end
        pending_next_s = (pending_r & ~grant_mask_s) | capture_s;
    end

    // Drop bookkeeping. A clear in the same cycle as a drop keeps only that cycle's drops.
    always_comb begin
        count_base_s = drop_count;
        if (clear_drops) begin
            count_base_s      = 8'd0;
            drop_flags_next_s = drop_s;
        end else begin
            drop_flags_next_s = drop_flags | drop_s;
        end
        count_sum_s       = {1'b0, count_base_s} + {1'b0, popcount(drop_s)};
        drop_count_next_s = count_sum_s[8] ? 8'd255 : count_sum_s[7:0];
    end

    // Output-stage next state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            EMPTY:   state_next_s = grant_valid_s ? FULL : EMPTY;
            FULL: begin
                if (out_ready) begin
                    state_next_s = grant_valid_s ? FULL : EMPTY;
                end else begin
                    state_next_s = FULL;
                end
            end
            default: state_next_s = EMPTY;
        endcase
    end

    // Output-stage state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Channel buffers, output payload, round-robin pointer and drop counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM; k++) begin
                hold_r[k] <= '0;
            end
            pending_r  <= '0;
            rr_ptr_r   <= ID_BITS'(NUM - 1);
            out_data   <= '0;
            out_id     <= '0;
            drop_flags <= '0;
            drop_count <= 8'd0;
        end else begin
            for (int k = 0; k < NUM; k++) begin
                if (capture_s[k]) begin
                    hold_r[k] <= in_data[k*WIDTH +: WIDTH];
                end
            end
            pending_r <= pending_next_s;
            if (grant_valid_s) begin
                out_data <= hold_r[grant_idx_s];
                out_id   <= grant_idx_s;
                rr_ptr_r <= grant_idx_s;
            end
            drop_flags <= drop_flags_next_s;
            drop_count <= drop_count_next_s;
        end
    end

endmodule
